// File: rtl/m_muldiv_pkg.sv
// Shared state encoding and ALU select codes for the MUL/DIV sequencer.
// Imported by m_muldiv_seq and m_muldiv_itercnt.
package m_muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [2:0] S_ALU_CLR   = 3'b000;
  localparam logic [2:0] S_ALU_SEED  = 3'b000;  // only meaningful together with sa14=1
  localparam logic [2:0] S_ALU_ADD   = 3'b110;
  localparam logic [2:0] S_ALU_SHIFT = 3'b111;

  localparam int FUNCT3_DIV_BIT = 2;

endpackage

// File: rtl/m_muldiv_itercnt.sv
// Iteration counter: clear wins over increment, saturates at NITER, tc flags NITER-1.
// Registered count, combinational terminal flag; no backpressure.
module m_muldiv_itercnt #(
  parameter int NITER = 32,
  parameter int CW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(NITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(NITER - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CNT_LAST);

endmodule

// File: rtl/m_muldiv_seq.sv
// MUL/DIV add/shift sequencer driving the condition-code block; optional skip-add via M_MULDIV_SEQ_SKIPADD_EN.
// INIT one cycle after start, DONE at cycle 2*NITER+2; start ignored while busy, abort returns to IDLE next edge.
module m_muldiv_seq
  import m_muldiv_pkg::*;
#(
  parameter int NITER = 32,
  parameter int CW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    funct3,
  input  logic          abort,
  input  logic          mlsb,
  output logic          busy,
  output logic          done,
  output logic          ceM,
  output logic          sa14,
  output logic [2:0]    s_alu,
  output logic          cond_holdq,
  output logic [CW-1:0] iter
);

  state_e     state_q, state_d;
  logic [2:0] funct3_q, funct3_d;
  logic       cnt_clr, cnt_inc, cnt_tc;
  logic       unused_bits;

  m_muldiv_itercnt #(
    .NITER (NITER),
    .CW    (CW)
  ) u_itercnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (iter),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ceM        = 1'b0;
    sa14       = 1'b0;
    s_alu      = S_ALU_CLR;
    cond_holdq = 1'b1;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          funct3_d = funct3;
          cnt_clr  = 1'b1;
          state_d  = INIT;
        end
      end
      INIT: begin
        busy       = 1'b1;
        sa14       = 1'b1;
        s_alu      = S_ALU_SEED;
        cond_holdq = 1'b0;
        state_d    = ADD;
      end
      ADD: begin
        busy       = 1'b1;
        s_alu      = S_ALU_ADD;
        cond_holdq = 1'b0;
`ifdef M_MULDIV_SEQ_SKIPADD_EN
        // Multiplier bit clear: hold rF instead of adding, keeping cycle count fixed.
        if (!funct3_q[FUNCT3_DIV_BIT] && !mlsb) begin
          s_alu      = S_ALU_CLR;
          cond_holdq = 1'b1;
        end
`endif
        state_d    = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        ceM        = 1'b1;
        s_alu      = S_ALU_SHIFT;
        cond_holdq = 1'b0;
        cnt_inc    = 1'b1;
        state_d    = cnt_tc ? DONE : ADD;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
      cnt_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      funct3_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
    end
  end

  // Operation type and mlsb only steer the optional skip-add path.
  assign unused_bits = ^{mlsb, funct3_q};

endmodule

// File: tb/tb_m_muldiv_seq.sv
// Bench for m_muldiv_seq: cycle-timeline reference model plus directed and random stimulus.
// Honours M_MULDIV_SEQ_SKIPADD_EN when the same define is given to the bench.
module tb_m_muldiv_seq;

  localparam int N      = 32;
  localparam int CWB    = 6;
  localparam int LAST_K = 2 * N + 2;
`ifdef M_MULDIV_SEQ_SKIPADD_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     funct3 = 3'b000;
  logic           abort = 1'b0;
  logic           mlsb = 1'b0;
  logic           busy, done, ceM, sa14, cond_holdq;
  logic [2:0]     s_alu;
  logic [CWB-1:0] iter;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  m_muldiv_seq #(.NITER(N), .CW(CWB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .funct3     (funct3),
    .abort      (abort),
    .mlsb       (mlsb),
    .busy       (busy),
    .done       (done),
    .ceM        (ceM),
    .sa14       (sa14),
    .s_alu      (s_alu),
    .cond_holdq (cond_holdq),
    .iter       (iter)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k = cycles since the accepted start (0 = idle).
  int         k = 0;
  int         iter_m = 0;
  logic [2:0] f3_m = 3'b000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0;
      iter_m = 0;
    end else if (k == 0) begin
      if (start && !abort) begin
        k = 1;
        f3_m = funct3;
        iter_m = 0;
      end
    end else if (abort) begin
      k = 0;
      iter_m = 0;
    end else if (k == LAST_K) begin
      k = 0;
      iter_m = N;
    end else begin
      k++;
    end
  end

  always @(negedge clk) begin
    int e_busy, e_done, e_cem, e_sa14, e_alu, e_hold, e_iter;
    if (chk_en) begin
      e_busy = 0; e_done = 0; e_cem = 0; e_sa14 = 0; e_alu = 0; e_hold = 1; e_iter = iter_m;
      if (rst) begin
        e_iter = 0;
      end else if (k == 1) begin
        e_busy = 1; e_sa14 = 1; e_hold = 0; e_iter = 0;
      end else if (k >= 2 && k <= 2 * N + 1) begin
        e_busy = 1;
        e_iter = (k - 2) / 2;
        if (k % 2 == 0) begin
          e_alu = 6; e_hold = 0;
          if (SKIP && !f3_m[2] && !mlsb) begin
            e_alu = 0; e_hold = 1;
          end
        end else begin
          e_cem = 1; e_alu = 7; e_hold = 0;
        end
      end else if (k == LAST_K) begin
        e_busy = 1; e_done = 1; e_iter = N;
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("ceM", ceM, e_cem);
      chk("sa14", sa14, e_sa14);
      chk("s_alu", s_alu, e_alu);
      chk("cond_holdq", cond_holdq, e_hold);
      chk("iter", iter, e_iter);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issues a start, then runs cycles 1..95 with optional abort/extra starts.
  task automatic run_op(input logic [2:0] f3, input bit rnd_mlsb, input int abort_c,
                        input int extra_c, input int restart_c, input int snap_c,
                        output int done_c, output int ndone, output int nhold,
                        output int iter_done, output int snap_busy, output int snap_iter);
    funct3 = f3;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_c = -1; ndone = 0; nhold = 0; iter_done = -1; snap_busy = -1; snap_iter = -1;
    for (int c = 1; c <= 95; c++) begin
      start = (c == extra_c) || (c == restart_c);
      abort = (c == abort_c);
      if (c == extra_c) funct3 = 3'b100;
      if (rnd_mlsb) mlsb = 1'($urandom);
      @(negedge clk);
      if (done) begin
        ndone++;
        done_c = c;
        iter_done = int'(iter);
      end
      if (c >= 2 && c <= 65 && (c % 2 == 0) && cond_holdq) nhold++;
      if (c == snap_c) begin
        snap_busy = int'(busy);
        snap_iter = int'(iter);
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  int dc, nd, nh, itd, sb, si;

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // Reset then idle
    repeat (10) tick();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_holdq", cond_holdq, 1);
    chk("idle_s_alu", s_alu, 0);
    chk("idle_iter", iter, 0);
    tick();

    // MULHU run with a start at cycle 10 and one coincident with done
    run_op(3'b011, 1'b1, 0, 10, 66, 1, dc, nd, nh, itd, sb, si);
    chk("mulhu_done_cycle", dc, 66);
    chk("mulhu_done_count", nd, 1);
    chk("mulhu_iter_at_done", itd, 32);
    chk("mulhu_busy_c1", sb, 1);

    // start together with abort in IDLE is rejected
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_rejected", busy, 0);
    tick();

    // Abort at cycle 20, restart during cycle 22
    run_op(3'($urandom), 1'b1, 20, 0, 22, 21, dc, nd, nh, itd, sb, si);
    chk("abort_busy_c21", sb, 0);
    chk("abort_iter_c21", si, 0);
    chk("restart_done_cycle", dc, 88);
    chk("restart_done_count", nd, 1);
    chk("restart_iter_at_done", itd, 32);

    // Skip-add behaviour: MUL and DIV with mlsb held low
    mlsb = 1'b0;
    run_op(3'b000, 1'b0, 0, 0, 0, 0, dc, nd, nh, itd, sb, si);
    chk("mul_lsb0_done_cycle", dc, 66);
    chk("mul_lsb0_hold_adds", nh, SKIP ? 32 : 0);
    run_op(3'b100, 1'b0, 0, 0, 0, 0, dc, nd, nh, itd, sb, si);
    chk("div_lsb0_done_cycle", dc, 66);
    chk("div_lsb0_hold_adds", nh, 0);

    // Asynchronous reset at cycle 30, between clock edges
    funct3 = 3'b001;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_iter", iter, 0);
    chk("async_rst_holdq", cond_holdq, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom % 6) == 0;
      abort  = ($urandom % 97) == 0;
      funct3 = 3'($urandom);
      mlsb   = 1'($urandom);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (70) tick();

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
